// File: rtl/sram_1p_arb_ctrl_if.sv
// Request/response bus between the SRAM arbiter and its two requesters.
//   wreq_*  : write request  (valid/ready, addr, data)
//   rreq_*  : read request   (valid/ready, addr)
//   rresp_* : read response  (valid/ready, data held by the controller)
// master = requester side, slave = controller side.
interface sram_1p_arb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wreq_valid;
  logic              wreq_ready;
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              rreq_valid;
  logic              rreq_ready;
  logic [ADDR_W-1:0] rreq_addr;
  logic              rresp_valid;
  logic              rresp_ready;
  logic [DATA_W-1:0] rresp_data;

  modport master (
    output wreq_valid, wreq_addr, wreq_data,
    output rreq_valid, rreq_addr, rresp_ready,
    input  wreq_ready, rreq_ready, rresp_valid, rresp_data
  );

  modport slave (
    input  wreq_valid, wreq_addr, wreq_data,
    input  rreq_valid, rreq_addr, rresp_ready,
    output wreq_ready, rreq_ready, rresp_valid, rresp_data
  );
endinterface

// File: rtl/sram_1p_arb_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset or on
// init_req, then arbitrates round-robin between one writer and one reader and
// holds read data in a register so the consumer never sees the raw macro Q.
// Ports:
//   CLK, RSTB        clock, asynchronous active-low reset
//   init_req         pulse in RUN: re-run the zero-fill
//   init_done        high while requests are being served
//   bus (slave)      write request, read request, read response handshakes
//   sram_ceb/web/a/d macro controls (active-low CEB/WEB)
//   sram_q           macro Q, valid only in the cycle after a read
//
// state | meaning
// ------+--------------------------------------------------------
// INIT  | writing zero to address init_cnt, no requests granted
// RUN   | arbitrating write/read requests
module sram_1p_arb_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              init_req,
  output logic              init_done,
  sram_1p_arb_ctrl_if.slave bus,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              rd_inflight;
  logic              last_grant_w;
  logic              rresp_valid_q;
  logic [DATA_W-1:0] rresp_data_q;
  logic              rd_elig;
  logic              arb_en;
  logic              grant_w;
  logic              grant_r;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
      ST_RUN:  if (init_req)              state_nxt = ST_INIT;
    endcase
  end

  // A read may only issue when nothing is in flight and the holding register
  // will be free by the time the new data lands.
  assign rd_elig = bus.rreq_valid && !rd_inflight && (!rresp_valid_q || bus.rresp_ready);
  assign arb_en  = (state == ST_RUN) && !init_req;
  assign grant_w = arb_en && bus.wreq_valid && (!rd_elig || !last_grant_w);
  assign grant_r = arb_en && rd_elig && !grant_w;

  // Macro pins are forced idle while RSTB is low, independent of the clock.
  always_comb begin
    sram_ceb       = 1'b1;
    sram_web       = 1'b1;
    sram_a         = '0;
    sram_d         = '0;
    init_done      = (state == ST_RUN);
    bus.wreq_ready = grant_w;
    bus.rreq_ready = grant_r;
    if (RSTB) begin
      if (state == ST_INIT) begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_a   = init_cnt;
      end else if (grant_w) begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_a   = bus.wreq_addr;
        sram_d   = bus.wreq_data;
      end else if (grant_r) begin
        sram_ceb = 1'b0;
        sram_a   = bus.rreq_addr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      init_cnt      <= '0;
      rd_inflight   <= 1'b0;
      last_grant_w  <= 1'b0;
      rresp_valid_q <= 1'b0;
      rresp_data_q  <= '0;
    end else begin
      // Parks at zero outside INIT so a re-fill always starts at address 0.
      if (state == ST_INIT && init_cnt != LAST_ADDR) init_cnt <= init_cnt + ADDR_W'(1);
      else                                           init_cnt <= '0;

      rd_inflight <= grant_r;

      if (grant_w)      last_grant_w <= 1'b1;
      else if (grant_r) last_grant_w <= 1'b0;

      // Capture wins over a same-cycle handoff so back-to-back data is kept.
      if (rd_inflight) begin
        rresp_valid_q <= 1'b1;
        rresp_data_q  <= sram_q;
      end else if (rresp_valid_q && bus.rresp_ready) begin
        rresp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rresp_valid = rresp_valid_q;
  assign bus.rresp_data  = rresp_data_q;

endmodule

// File: doc/sram_1p_arb_ctrl.md
Name: sram_1p_arb_ctrl

Overview:
- Controller in front of one single-port SRAM macro (active-low CEB/WEB, registered Q that is valid only in the cycle after a read and garbage otherwise).
- Zero-fills the whole array after reset or on request.
- Then shares the macro between one write requester and one read requester using valid/ready handshakes and round-robin arbitration.
- Captures read data into a holding register so the consumer never samples the unstable Q.

Parameters:
DATA_W, 32, data width; equals the macro Bits
DEPTH, 32, number of words; equals the macro Word_Depth
ADDR_W, 5, address width; equals the macro Add_Width, and DEPTH <= 2^ADDR_W

Ports:
CLK  in  1  clock
RSTB  in  1  asynchronous active-low reset
init_req  in  1  pulse: re-run the zero-fill
init_done  out  1  high when the array is cleared and requests are served
wreq_valid  in  1  write request valid
wreq_ready  out  1  write accepted this cycle
wreq_addr  in  ADDR_W  write address
wreq_data  in  DATA_W  write data
rreq_valid  in  1  read request valid
rreq_ready  out  1  read accepted this cycle
rreq_addr  in  ADDR_W  read address
rresp_valid  out  1  read data held and valid
rresp_ready  in  1  consumer takes rresp_data
rresp_data  out  DATA_W  read data
sram_ceb  out  1  macro CEB
sram_web  out  1  macro WEB
sram_a  out  ADDR_W  macro A
sram_d  out  DATA_W  macro D
sram_q  in  DATA_W  macro Q

Behaviour:
- Reset (RSTB low, asynchronous):
  - State INIT, init_cnt=0, rd_inflight=0, rresp_valid=0, rresp_data=0, last_grant=READ, init_done=0.
  - Both ready outputs are 0. sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
  - Asserting RSTB mid-operation drops any in-flight read or held response. Zero-fill restarts after release.
- State INIT:
  - Each cycle: sram_ceb=0, sram_web=0, sram_a=init_cnt, sram_d=0; init_cnt increments.
  - After writing address DEPTH-1, go to RUN. The fill takes exactly DEPTH cycles.
  - wreq_ready=rreq_ready=0 throughout. init_req is ignored in INIT.
- State RUN:
  - init_done=1.
  - init_req=1: go to INIT next cycle with init_cnt=0. Requests are not granted in the init_req cycle.
  - A held rresp and an in-flight read both complete normally across the transition.
- Read eligibility: rd_elig = rreq_valid && !rd_inflight && (!rresp_valid || rresp_ready). Maximum read throughput is 1 per 2 cycles.
- Arbitration (combinational, RUN only):
  - Grant write if wreq_valid and (!rd_elig or last_grant==READ).
  - Otherwise grant read if rd_elig.
  - last_grant updates to the granted side on every grant. It holds when nothing is granted.
  - wreq_ready=1 only on a write grant; rreq_ready=1 only on a read grant.
- Write grant cycle: sram_ceb=0, sram_web=0, sram_a=wreq_addr, sram_d=wreq_data. The array updates at that edge.
- Read grant cycle T:
  - sram_ceb=0, sram_web=1, sram_a=rreq_addr; rd_inflight=1 for cycle T+1.
  - At the end of T+1, rresp_data<=sram_q and rresp_valid<=1; rd_inflight clears.
  - rresp_valid is first visible in T+2 (2-cycle request-to-response latency).
- No grant: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- rresp handshake:
  - rresp_valid clears on rresp_valid && rresp_ready unless a capture happens in the same cycle; capture has priority and keeps rresp_valid=1.
  - rresp_data is stable while rresp_valid=1 and rresp_ready=0.
- sram_q is sampled only in the cycle after a read grant and ignored otherwise.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Write and read to the same address in the same cycle: only the granted one issues; the other waits.
- Addresses >= DEPTH are illegal and not checked.

Test Plan:
- Release RSTB -> exactly 32 cycles of CEB=0/WEB=0 with A=0..31 and D=0; init_done rises on cycle 33; every word then reads 0.
- In RUN: write addr 5 data 0xDEADBEEF, then read addr 5 the next cycle -> rreq_ready in the read cycle; rresp_valid two cycles later with data 0xDEADBEEF.
- Both requesters held valid with rresp_ready=1 for 8 cycles -> grants alternate, starting with write after reset (last_grant=READ); reads never issue back-to-back.
- Read completes with rresp_ready=0 for 5 cycles -> rresp_data stable, rreq_ready=0 while a new read is pending, writes still granted; raising rresp_ready releases the data and the read is granted the same cycle.
- Pulse init_req one cycle after a read grant -> the response is still delivered with the pre-clear data; 32 zero-fill cycles follow; then a read of that address returns 0.
- Drop RSTB during INIT at init_cnt=10 and again with rresp_valid=1 -> outputs return to reset values immediately; fill restarts at 0; no response is emitted.
